dram_ctrl: RTL
==============

Name: dram_ctrl

Overview:
- Sits directly downstream of the MEM stage, between its single-cycle RAM port and a multi-cycle data bus.
- Converts each MEM-stage RAM read or write into one valid/ready bus transaction.
- Stalls the pipeline until the transaction completes, then returns read data to the MEM stage.
- Flags bus errors and timeouts so the MEM stage can raise load/store access faults.

Parameters:
- XLEN, 64, data/address width; the RAM is 8 bytes wide and addresses are doubleword-aligned.
- TIMEOUT, 255, cycles allowed in WAIT_RSP before a timeout error is forced; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush
- ram_addr_i  in  XLEN  doubleword address from MEM stage; low 3 bits are always 0
- ram_ren_i  in  1  read request (level)
- ram_wen_i  in  1  write request (level)
- ram_byte_en_i  in  8  write byte enables
- ram_wdata_i  in  XLEN  write data, already lane-replicated
- ram_rdata_o  out  XLEN  read data back to MEM stage
- stall_o  out  1  hold the pipeline (MEM and earlier stages)
- bus_err_o  out  1  one-cycle pulse in DONE on bus error or timeout
- bus_req_valid_o  out  1  request valid
- bus_req_ready_i  in  1  request accepted
- bus_req_we_o  out  1  1 = write, 0 = read
- bus_req_addr_o  out  XLEN  request address
- bus_req_wstrb_o  out  8  write strobes
- bus_req_wdata_o  out  XLEN  write data
- bus_rsp_valid_i  in  1  response valid (single cycle)
- bus_rsp_rdata_i  in  XLEN  response data
- bus_rsp_err_i  in  1  response error, qualified by bus_rsp_valid_i

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: state IDLE, all outputs 0, rdata register 0, timeout counter 0.
- Request: req = ram_ren_i | ram_wen_i. Both asserted together is illegal; write wins. The MEM stage holds its inputs stable while stall_o = 1.
- IDLE:
  - req & !flush_i -> latch addr/we/wstrb/wdata into request registers, go to REQ.
  - stall_o = req & !flush_i, combinationally in the same cycle.
- REQ:
  - bus_req_valid_o = 1 and request registers drive the bus; stall_o = 1.
  - bus_req_ready_i -> go to WAIT_RSP.
  - flush_i before the handshake -> abort, drop valid, go to IDLE (no bus side effect).
  - Valid may not drop and fields may not change until ready, except on that abort.
- WAIT_RSP:
  - stall_o = 1; counter increments each cycle.
  - bus_rsp_valid_i -> capture rdata (reads only; writes leave the rdata register unchanged) and err, go to DONE.
  - Counter reaching TIMEOUT (TIMEOUT > 0) -> err = 1, go to DONE; a later stray response is ignored.
  - A response arriving in the same cycle the timeout fires takes priority over the timeout.
  - flush_i while here: the accepted transaction still drains; set a discard flag.
- DONE (exactly one cycle):
  - stall_o = 0; ram_rdata_o = captured data.
  - bus_err_o = err & !discard.
  - Next state IDLE; a new req is not accepted in the DONE cycle.
  - Back-to-back accesses cost at least 4 cycles each: IDLE, REQ, WAIT_RSP, DONE.
- ram_rdata_o holds its last value outside DONE.
- Counter clears on every entry to WAIT_RSP.
- Reset asserted mid-transaction returns to IDLE immediately; the bus side must tolerate the abandoned request.

Optional Feature:
- Macro: DRAM_LINE_BUF_EN.
- Defined: adds a one-entry read buffer (tag = addr[XLEN-1:3], data, valid).
  - A read in IDLE whose tag matches a valid entry skips REQ/WAIT_RSP and goes straight to DONE.
  - The entry fills on every successful read response.
  - Any write to the same tag updates the entry per byte using wstrb.
  - An errored read invalidates the entry; flush does not.
- Undefined: every access goes to the bus; no buffer logic is present.

Decomposition:
- Shared package: state encoding localparams (IDLE, REQ, WAIT_RSP, DONE), DRAM_LINE_BYTES = 8, DRAM_TIMEOUT_DEF = 255.
- Sub-module dram_line_buf holds the optional buffer (lookup, fill, byte merge), instantiated only under DRAM_LINE_BUF_EN.

Test Plan:
- Read at 0x1000, ready after 2 cycles, rsp 3 cycles later with 0x1122334455667788 -> stall_o high from request cycle through WAIT_RSP, ram_rdata_o = 0x1122334455667788 in DONE, bus_err_o = 0.
- Write 0x2008, byte_en 0xF0, wdata 0xAABBCCDD_AABBCCDD, ready immediately -> one req beat with we = 1, wstrb = 0xF0; stall_o drops in DONE; ram_rdata_o unchanged.
- flush_i in REQ before ready -> valid drops the next cycle, state IDLE, no response expected. flush_i in WAIT_RSP -> response drained, bus_err_o suppressed even with rsp_err = 1.
- TIMEOUT = 4, no response -> bus_err_o = 1 in DONE on the 5th WAIT_RSP-exit cycle; a late bus_rsp_valid_i is ignored.
- rsp_err = 1 on a read of 0x3000 -> bus_err_o pulses for exactly 1 cycle; stall released.
- With DRAM_LINE_BUF_EN: read 0x1000 twice -> second read completes in 2 cycles with no bus_req_valid_o. sb to 0x1003 (byte_en 0x08, data 0x5A) then read 0x1000 -> byte 3 = 0x5A, still no bus read.

Source files
------------

// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage DRAM bus controller.
package dram_ctrl_pkg;

  localparam int unsigned DRAM_LINE_BYTES  = 8;
  localparam int unsigned DRAM_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } dram_state_e;

endpackage

// File: rtl/dram_line_buf.sv
// One-entry read line buffer: tag lookup, fill on read response, byte merge on write.
// Instantiated by dram_ctrl only when DRAM_LINE_BUF_EN is defined.
module dram_line_buf
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [XLEN-4:0]            lookup_tag,
  output logic                       hit_c,
  output logic [XLEN-1:0]            data_c,
  input  logic                       fill_en,
  input  logic                       wr_en,
  input  logic                       inval_en,
  input  logic [XLEN-4:0]            upd_tag,
  input  logic [XLEN-1:0]            upd_data,
  input  logic [DRAM_LINE_BYTES-1:0] upd_strb
);

  logic                valid_q;
  logic [XLEN-4:0]     tag_q;
  logic [XLEN-1:0]     data_q;
  logic [XLEN-1:0]     merged;

  assign hit_c  = valid_q && (tag_q == lookup_tag);
  assign data_c = data_q;

  // Per-byte merge of write data into the held line
  always_comb begin
    merged = data_q;
    for (int unsigned i = 0; i < DRAM_LINE_BYTES; i++) begin
      if (upd_strb[i]) merged[8*i +: 8] = upd_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (inval_en) begin
      valid_q <= 1'b0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      tag_q   <= upd_tag;
      data_q  <= upd_data;
    end else if (wr_en && valid_q && (tag_q == upd_tag)) begin
      data_q  <= merged;
    end
  end

endmodule

// File: rtl/dram_ctrl.sv
// Bridges the single-cycle MEM-stage RAM port onto a valid/ready data bus, stalling until done.
// Optional one-entry read buffer enabled by defining DRAM_LINE_BUF_EN.
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = DRAM_TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic [XLEN-1:0]            ram_addr_i,
  input  logic                       ram_ren_i,
  input  logic                       ram_wen_i,
  input  logic [DRAM_LINE_BYTES-1:0] ram_byte_en_i,
  input  logic [XLEN-1:0]            ram_wdata_i,
  output logic [XLEN-1:0]            ram_rdata_o,
  output logic                       stall_o,
  output logic                       bus_err_o,
  output logic                       bus_req_valid_o,
  input  logic                       bus_req_ready_i,
  output logic                       bus_req_we_o,
  output logic [XLEN-1:0]            bus_req_addr_o,
  output logic [DRAM_LINE_BYTES-1:0] bus_req_wstrb_o,
  output logic [XLEN-1:0]            bus_req_wdata_o,
  input  logic                       bus_rsp_valid_i,
  input  logic [XLEN-1:0]            bus_rsp_rdata_i,
  input  logic                       bus_rsp_err_i
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  dram_state_e                state_q, state_d;
  logic                       req_we_q;
  logic [XLEN-1:0]            req_addr_q;
  logic [DRAM_LINE_BYTES-1:0] req_wstrb_q;
  logic [XLEN-1:0]            req_wdata_q;
  logic                       err_q, err_d;
  logic                       discard_q, discard_d;
  logic [XLEN-1:0]            rdata_q, rdata_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       load;
  logic                       req_c;
  logic                       timeout_c;
  logic                       buf_hit_c;
  logic [XLEN-1:0]            buf_data_c;

  assign req_c     = ram_ren_i | ram_wen_i;
  assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  // Next-state and stall logic
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    discard_d = discard_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    stall_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_c && !flush_i) begin
          stall_o   = 1'b1;
          load      = 1'b1;
          err_d     = 1'b0;
          discard_d = 1'b0;
          if (buf_hit_c && !ram_wen_i) begin
            state_d = DONE;
            rdata_d = buf_data_c;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (bus_req_ready_i) begin
          // Handshake already happened, so a same-cycle flush can only discard the result
          state_d   = WAIT_RSP;
          cnt_d     = '0;
          discard_d = flush_i;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      WAIT_RSP: begin
        stall_o = 1'b1;
        if (flush_i) discard_d = 1'b1;
        if (bus_rsp_valid_i) begin
          state_d = DONE;
          err_d   = bus_rsp_err_i;
          if (!req_we_q) rdata_d = bus_rsp_rdata_i;
        end else if (timeout_c) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wstrb_q <= '0;
      req_wdata_q <= '0;
      err_q       <= 1'b0;
      discard_q   <= 1'b0;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      discard_q <= discard_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      if (load) begin
        req_we_q    <= ram_wen_i;
        req_addr_q  <= ram_addr_i;
        req_wstrb_q <= ram_byte_en_i;
        req_wdata_q <= ram_wdata_i;
      end
    end
  end

  assign bus_req_valid_o = (state_q == REQ);
  assign bus_req_we_o    = req_we_q;
  assign bus_req_addr_o  = req_addr_q;
  assign bus_req_wstrb_o = req_wstrb_q;
  assign bus_req_wdata_o = req_wdata_q;
  assign bus_err_o       = (state_q == DONE) && err_q && !discard_q;
  assign ram_rdata_o     = rdata_q;

`ifdef DRAM_LINE_BUF_EN
  logic buf_fill;
  logic buf_wr;
  logic buf_inval;

  // Timeouts count as errored reads and invalidate the entry too
  assign buf_fill  = (state_q == WAIT_RSP) && bus_rsp_valid_i && !bus_rsp_err_i && !req_we_q;
  assign buf_wr    = (state_q == WAIT_RSP) && bus_rsp_valid_i && !bus_rsp_err_i && req_we_q;
  assign buf_inval = (state_q == WAIT_RSP) && !req_we_q &&
                     ((bus_rsp_valid_i && bus_rsp_err_i) || (!bus_rsp_valid_i && timeout_c));

  dram_line_buf #(.XLEN(XLEN)) u_line_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_tag (ram_addr_i[XLEN-1:3]),
    .hit_c      (buf_hit_c),
    .data_c     (buf_data_c),
    .fill_en    (buf_fill),
    .wr_en      (buf_wr),
    .inval_en   (buf_inval),
    .upd_tag    (req_addr_q[XLEN-1:3]),
    .upd_data   (req_we_q ? req_wdata_q : bus_rsp_rdata_i),
    .upd_strb   (req_wstrb_q)
  );
`else
  assign buf_hit_c  = 1'b0;
  assign buf_data_c = '0;
`endif

endmodule
